// File: rtl/control_maximo_pkg.sv
// control_maximo shared types and defaults.
// Build option: define INDICE_EN to keep the index-of-maximum register.
package control_maximo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FIRST = 2'd1,
    SCAN  = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int W_DEF  = 4;
  localparam int N_DEF  = 8;
  localparam int IW_DEF = 4;

endpackage

// File: rtl/control_maximo_if.sv
// Sample/result bundle between the source, control_maximo and the consumer.
// master drives samples and start; slave is the controller.
interface control_maximo_if
  import control_maximo_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int IW = IW_DEF
);

  logic          start;
  logic [W-1:0]  din;
  logic          din_valid;
  logic          din_ready;
  logic [W-1:0]  max_out;
  logic [IW-1:0] idx_out;
  logic          done;
  logic          busy;

  modport master (
    output start,
    output din,
    output din_valid,
    input  din_ready,
    input  max_out,
    input  idx_out,
    input  done,
    input  busy
  );

  modport slave (
    input  start,
    input  din,
    input  din_valid,
    output din_ready,
    output max_out,
    output idx_out,
    output done,
    output busy
  );

endinterface

// File: rtl/control_maximo_mayorigual.sv
// mayorigual: unsigned A >= B comparator.
// Pure combinational; width W.
module mayorigual #(
  parameter int W = 4
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic         ge_o
);

  assign ge_o = (a_i >= b_i);

endmodule

// File: rtl/control_maximo.sv
// control_maximo: frame maximum search over a valid/ready sample stream.
// Build option: INDICE_EN keeps idx_out; otherwise idx_out is tied to 0.
module control_maximo
  import control_maximo_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int N  = N_DEF,
  parameter int IW = IW_DEF
) (
  input  logic clk,
  input  logic rstn,
  control_maximo_if.slave bus
);

  // count is one bit wider than the index so N = 2^IW does not wrap
  localparam logic [IW:0] N_CNT = (IW+1)'(N);
  localparam logic [IW:0] ONE   = (IW+1)'(1);

  state_e        state_q, state_d;
  logic [IW:0]   cnt_q, cnt_d;
  logic [W-1:0]  max_q, max_d;
  logic          hs;
  logic          ge;
  logic          act;

  assign act = (state_q == FIRST) || (state_q == SCAN);
  assign hs  = bus.din_valid & act;

  mayorigual #(
    .W(W)
  ) u_mayorigual (
    .a_i  (max_q),
    .b_i  (bus.din),
    .ge_o (ge)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    max_d   = max_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = FIRST;
          cnt_d   = '0;
        end
      end
      FIRST: begin
        if (hs) begin
          max_d   = bus.din;
          cnt_d   = ONE;
          state_d = (N_CNT == ONE) ? DONE : SCAN;
        end
      end
      SCAN: begin
        if (hs) begin
          if (!ge) max_d = bus.din;
          cnt_d = cnt_q + ONE;
          if (cnt_d == N_CNT) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      max_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      max_q   <= max_d;
    end
  end

`ifdef INDICE_EN
  logic [IW-1:0] idx_q, idx_d;

  // strict greater-than moves the index, so ties keep the earliest one
  always_comb begin
    idx_d = idx_q;
    unique case (1'b1)
      (state_q == FIRST) && hs:       idx_d = '0;
      (state_q == SCAN) && hs && !ge: idx_d = cnt_q[IW-1:0];
      default:                        idx_d = idx_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) idx_q <= '0;
    else       idx_q <= idx_d;
  end

  assign bus.idx_out = idx_q;
`else
  assign bus.idx_out = '0;
`endif

  assign bus.din_ready = act;
  assign bus.busy      = act;
  assign bus.done      = (state_q == DONE);
  assign bus.max_out   = max_q;

endmodule

// File: tb/tb_control_maximo.sv
// Bench for control_maximo: table frames, random frames, reset and N=1.
// Expected results come from a frame-level max/first-index model.
module tb_control_maximo;

`ifdef INDICE_EN
  localparam bit IDX_ON = 1'b1;
`else
  localparam bit IDX_ON = 1'b0;
`endif

  logic clk;
  logic rstn;
  int   checks;
  int   failures;

  control_maximo_if #(.W(4), .IW(4)) bus ();
  control_maximo_if #(.W(4), .IW(4)) b1 ();

  control_maximo #(.W(4), .N(8), .IW(4)) u8 (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  control_maximo #(.W(4), .N(1), .IW(4)) u1 (
    .clk  (clk),
    .rstn (rstn),
    .bus  (b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string          nm;
    logic [7:0][3:0] v;
    int             pat;
    bit             poke;
    logic [3:0]     emax;
    int             eidx;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", n, act, exp);
    end
  endtask

  function automatic logic [7:0][3:0] pk(
      input int a0, input int a1, input int a2, input int a3,
      input int a4, input int a5, input int a6, input int a7);
    logic [7:0][3:0] r;
    r[0] = 4'(a0); r[1] = 4'(a1); r[2] = 4'(a2); r[3] = 4'(a3);
    r[4] = 4'(a4); r[5] = 4'(a5); r[6] = 4'(a6); r[7] = 4'(a7);
    return r;
  endfunction

  // reference: largest value, earliest position among equals
  task automatic ref_max(input logic [7:0][3:0] v,
                         output logic [3:0] m, output int ix);
    int best;
    best = -1;
    ix   = 0;
    for (int i = 0; i < 8; i++) begin
      if (int'(v[i]) > best) begin
        best = int'(v[i]);
        ix   = i;
      end
    end
    m = 4'(best);
  endtask

  task automatic run_frame(input string nm, input logic [7:0][3:0] v,
                           input int pat, input bit poke,
                           input logic [3:0] em, input int ei);
    int cyc, k, idle, dcyc;
    bit vld;
    bus.start     = 1'b1;
    bus.din_valid = 1'b1;
    bus.din       = 4'hF;
    chk({nm, "_idle_ready"}, 32'(bus.din_ready), 0);
    @(posedge clk); #1;
    cyc = 1;
    bus.start = 1'b0;
    chk({nm, "_ready_after_start"}, 32'(bus.din_ready), 1);
    k    = 0;
    idle = 0;
    dcyc = -1;
    while (cyc < 100) begin
      if (bus.done) begin
        dcyc = cyc;
        break;
      end
      case (pat)
        0:       vld = 1'b1;
        1:       vld = (cyc % 2) == 1;
        default: vld = 1'($urandom_range(0, 1));
      endcase
      if (k >= 8) vld = 1'b0;
      bus.din_valid = vld;
      bus.din       = vld ? v[k] : 4'($urandom);
      bus.start     = poke && (k == 4);
      if (bus.din_ready) begin
        if (vld) k++;
        else     idle++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk({nm, "_done_cycle"}, 32'(dcyc), 32'(9 + idle));
    chk({nm, "_max"}, 32'(bus.max_out), 32'(em));
    chk({nm, "_idx"}, 32'(bus.idx_out), IDX_ON ? 32'(ei) : 0);
    chk({nm, "_busy_in_done"}, 32'(bus.busy), 0);
    bus.start     = poke;
    bus.din_valid = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk({nm, "_single_done"}, 32'(bus.done), 0);
    chk({nm, "_idle_after"}, 32'(bus.busy), 0);
    @(posedge clk); #1;
    chk({nm, "_no_queued_start"},
        32'({bus.busy, bus.done, bus.din_ready}), 0);
    chk({nm, "_max_hold"}, 32'(bus.max_out), 32'(em));
  endtask

  initial begin
    logic [7:0][3:0] rv;
    logic [3:0] rm;
    int ri;
    checks   = 0;
    failures = 0;

    tbl[0] = '{"seq",     pk(3,9,2,12,4,12,1,0), 0, 1'b0, 4'd12, 3};
    tbl[1] = '{"seq_alt", pk(3,9,2,12,4,12,1,0), 1, 1'b0, 4'd12, 3};
    tbl[2] = '{"all15",   pk(15,15,15,15,15,15,15,15), 0, 1'b0, 4'd15, 0};
    tbl[3] = '{"all0",    pk(0,0,0,0,0,0,0,0), 0, 1'b0, 4'd0, 0};
    tbl[4] = '{"poke",    pk(1,2,3,4,5,6,7,8), 0, 1'b1, 4'd8, 7};

    bus.start = 1'b0; bus.din = '0; bus.din_valid = 1'b0;
    b1.start  = 1'b0; b1.din  = '0; b1.din_valid  = 1'b0;
    rstn = 1'b0;
    #12;
    chk("rst_outputs",
        32'({bus.din_ready, bus.done, bus.busy, bus.max_out, bus.idx_out}),
        0);
    chk("rst_outputs_n1",
        32'({b1.din_ready, b1.done, b1.busy, b1.max_out, b1.idx_out}), 0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;

    for (int t = 0; t < 5; t++)
      run_frame(tbl[t].nm, tbl[t].v, tbl[t].pat, tbl[t].poke,
                tbl[t].emax, tbl[t].eidx);

    // reset in the middle of a frame
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.din_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.din = 4'(1 + 4 * i);
      @(posedge clk); #1;
    end
    chk("pre_rst_busy", 32'(bus.busy), 1);
    chk("pre_rst_max", 32'(bus.max_out), 9);
    #2;
    rstn = 1'b0;
    #1;
    chk("midframe_rst",
        32'({bus.din_ready, bus.done, bus.busy, bus.max_out, bus.idx_out}),
        0);
    bus.din_valid = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    run_frame("after_rst", pk(2,6,6,1,0,5,3,4), 0, 1'b0, 4'd6, 1);

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 8; i++) rv[i] = 4'($urandom);
      ref_max(rv, rm, ri);
      run_frame($sformatf("rand%0d", r), rv, 2, 1'($urandom_range(0, 1)),
                rm, ri);
    end

    // single-sample frame
    b1.start = 1'b1;
    @(posedge clk); #1;
    b1.start     = 1'b0;
    b1.din       = 4'd7;
    b1.din_valid = 1'b1;
    chk("n1_ready", 32'(b1.din_ready), 1);
    @(posedge clk); #1;
    b1.din_valid = 1'b0;
    chk("n1_done", 32'(b1.done), 1);
    chk("n1_max", 32'(b1.max_out), 7);
    chk("n1_idx", 32'(b1.idx_out), 0);
    @(posedge clk); #1;
    chk("n1_done_pulse", 32'({b1.done, b1.busy}), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/control_maximo.md
# control_maximo

Sequential controller that drives the `mayorigual` (A ≥ B) comparator to find the maximum of a frame of N unsigned samples. Samples are accepted one per cycle over a valid/ready handshake. The block holds the running maximum and, optionally, its position in the frame. It reports the result with a one-cycle `done` pulse. It sits between a sample source and whatever consumes the frame maximum.

## Interface
- `W`, 4, sample width in bits (matches the comparator width).
- `N`, 8, samples per frame; legal range 1..16.
- `IW`, 4, index width; must satisfy 2^IW ≥ N.
- `clk`  input  1  system clock; all state changes on the rising edge.
- `rstn`  input  1  reset; asynchronous, active-low.
- `start`  input  1  begins a frame; sampled only in IDLE.
- `din`  input  W  sample value.
- `din_valid`  input  1  `din` is valid this cycle.
- `din_ready`  output  1  block accepts `din` this cycle.
- `max_out`  output  W  frame maximum; valid from `done` until the next `start`.
- `idx_out`  output  IW  0-based position of the first occurrence of the maximum.
- `done`  output  1  one-cycle pulse; result is valid.
- `busy`  output  1  a frame is in progress (FIRST or SCAN).

## Operation
- FSM states: IDLE, FIRST, SCAN, DONE.
- Handshake: a sample is consumed only when `din_valid` and `din_ready` are both high at a clock edge. `din_valid` may drop at any time; no sample is lost or duplicated.
- IDLE:
  - `din_ready` = 0.
  - `start` = 1 → FIRST, sample count cleared.
  - `din_valid` is ignored in IDLE.
- FIRST:
  - `din_ready` = 1.
  - On handshake: max ← din, idx ← 0, count ← 1.
  - If N = 1 → DONE; otherwise → SCAN.
- SCAN:
  - `din_ready` = 1.
  - Comparator inputs: A = stored max, B = din.
  - On handshake, if A ≥ B, the stored max is kept. Otherwise max ← din and idx ← count.
  - Ties therefore keep the earliest index.
  - count increments on every handshake. The handshake that brings count to N → DONE.
- DONE:
  - `done` = 1 for exactly one cycle, then → IDLE.
  - `max_out`/`idx_out` hold their values until the next FIRST handshake.
- `start` while `busy` or in DONE is ignored; it has no queuing effect.
- Arithmetic: unsigned throughout; count width is IW+1 so that N = 16 does not wrap.

## Timing
- Reset values: state IDLE; `din_ready` 0, `max_out` 0, `idx_out` 0, `done` 0, `busy` 0.
- `start` → `din_ready` high on the next cycle.
- Throughput: 1 sample per cycle when `din_valid` is held high.
- Frame latency: `done` is high in the cycle after the N-th handshake. The minimum from `start` to `done` is N+1 cycles.
- `max_out`/`idx_out` update registered, one edge after each handshake. They are stable in the `done` cycle.
- `din_ready`, `busy` and `done` are decoded from registered state only; there is no combinational path from `din_valid` to `din_ready`.
- Reset asserted mid-frame immediately returns all state and outputs to their reset values. The partial frame is discarded.
- `start` and the first `din_valid` in the same cycle: that `din` is not consumed, because `din_ready` is still 0.

## Configuration
- `INDICE_EN` defined: the index register and its update logic are built, and `idx_out` behaves as above.
- `INDICE_EN` undefined:
  - The index register is removed and `idx_out` is tied to 0.
  - `max_out`, the handshake and timing are unchanged.

## Structure
- Shared package `control_maximo_pkg` holds:
  - the state enum/localparams (IDLE=0, FIRST=1, SCAN=2, DONE=3);
  - defaults `W_DEF` = 4 and `N_DEF` = 8.
- One sub-module instance: `mayorigual`, width W, with A = stored max, B = din.
- FSM, counter and registers live in `control_maximo` itself.

## Test plan
- Reset check: assert `rstn` = 0 mid-SCAN → all outputs 0 and state IDLE; after release, `start` runs a fresh frame correctly.
- N = 8, din = 3, 9, 2, 12, 4, 12, 1, 0 with `din_valid` held high → `done` at cycle 9 after `start`; `max_out` = 12, `idx_out` = 3 (first tie wins).
- Same frame with `din_valid` deasserted on alternate cycles → identical result; `done` delayed by exactly the number of idle cycles.
- All samples = 15 → `max_out` = 15, `idx_out` = 0. All samples = 0 → `max_out` = 0, `idx_out` = 0.
- `start` pulsed during SCAN and in the DONE cycle → ignored; only one `done` pulse; the next frame requires a new `start` in IDLE.
- N = 1, din = 7 → `done` 2 cycles after `start`, `max_out` = 7. Build without `INDICE_EN` → `idx_out` stays 0 in every scenario.
